// File: rtl/bin2onehot_stream_if.sv
// Stream bundle between an index-code producer, the one-hot decoder and its consumer.
// master drives codes and consumes words; slave is the decoder side.
interface bin2onehot_stream_if #(
    parameter int N = 64
);
    localparam int K = $clog2(N);

    logic [K:0]   in_code;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] onehot_out;
    logic         out_valid;
    logic         out_ready;
    logic         err_clr;
    logic         err;
    logic [7:0]   err_count;

    modport master (
        output in_code, in_valid, out_ready, err_clr,
        input  in_ready, onehot_out, out_valid, err, err_count
    );

    modport slave (
        input  in_code, in_valid, out_ready, err_clr,
        output in_ready, onehot_out, out_valid, err, err_count
    );
endinterface

// File: rtl/bin2onehot_stream.sv
// Purpose: buffers {valid, index} codes in a 2-entry FIFO and presents the head as a one-hot word.
// Latency: one cycle from push into an empty buffer to out_valid; one word per cycle sustained.
// Backpressure: in_ready drops only when both entries are held; ready/valid derive from state alone.
module bin2onehot_stream #(
    parameter int N = 64
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    bin2onehot_stream_if.slave bus
);
    localparam int K     = $clog2(N);
    localparam int DEPTH = 2;
    localparam logic [K:0] N_LIM = (K+1)'(N);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [K:0] mem [DEPTH];
    logic       wr_ptr;
    logic       rd_ptr;
    logic       in_ready_c;
    logic       out_valid_c;
    logic       push;
    logic       pop;
    logic [K:0] head;
    logic       head_in_range;
    logic       code_oor;
    logic       oor_push;
    logic [N-1:0] onehot_c;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Push and pop conditions are folded into the transitions so that
    // push+pop in ONE holds, and a pop in FULL never admits a push.
    always_comb begin
        state_nxt   = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state)
            EMPTY: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_nxt = ONE;
            end
            ONE: begin
                in_ready_c  = 1'b1;
                out_valid_c = 1'b1;
                if (bus.in_valid && !bus.out_ready)      state_nxt = FULL;
                else if (!bus.in_valid && bus.out_ready) state_nxt = EMPTY;
            end
            FULL: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) state_nxt = ONE;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    assign push = bus.in_valid && in_ready_c;
    assign pop  = out_valid_c && bus.out_ready;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
        end
    end

    // Entry contents need no reset; they are only observed while out_valid is high.
    always_ff @(posedge wb_clk_i) begin
        if (push) mem[wr_ptr] <= bus.in_code;
    end

    // Codes are stored raw and decoded at the head to keep the storage K+1 bits wide.
    assign head          = mem[rd_ptr];
    assign head_in_range = {1'b0, head[K-1:0]} < N_LIM;

    always_comb begin
        onehot_c = '0;
        if (out_valid_c && head[K] && head_in_range) onehot_c[head[K-1:0]] = 1'b1;
    end

    assign code_oor = bus.in_code[K] && ({1'b0, bus.in_code[K-1:0]} >= N_LIM);
    assign oor_push = push && code_oor;

    // A clear coinciding with an out-of-range push leaves that push counted.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            bus.err       <= 1'b0;
            bus.err_count <= 8'd0;
        end else if (bus.err_clr) begin
            bus.err       <= oor_push;
            bus.err_count <= {7'd0, oor_push};
        end else if (oor_push) begin
            bus.err <= 1'b1;
            if (bus.err_count != 8'hFF) bus.err_count <= bus.err_count + 8'd1;
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = out_valid_c;
    assign bus.onehot_out = onehot_c;
endmodule

// File: tb/tb_bin2onehot_stream.sv
// Drives identical code streams into an N=64 and an N=48 decoder and checks both
// against a queue-based reference model plus table and directed sequences.
module tb_bin2onehot_stream;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] code = '0;
    logic       vld  = 1'b0;
    logic       ordy = 1'b0;
    logic       eclr = 1'b0;

    int vectors    = 0;
    int miscompares = 0;

    logic [6:0] mq[$];
    int e48 = 0, c48 = 0, e64 = 0, c64 = 0;

    bin2onehot_stream_if #(.N(64)) b64 ();
    bin2onehot_stream_if #(.N(48)) b48 ();

    assign b64.in_code   = code;
    assign b64.in_valid  = vld;
    assign b64.out_ready = ordy;
    assign b64.err_clr   = eclr;
    assign b48.in_code   = code;
    assign b48.in_valid  = vld;
    assign b48.out_ready = ordy;
    assign b48.err_clr   = eclr;

    bin2onehot_stream #(.N(64)) dut64 (.wb_clk_i(clk), .wb_rst_i(rst), .bus(b64));
    bin2onehot_stream #(.N(48)) dut48 (.wb_clk_i(clk), .wb_rst_i(rst), .bus(b48));

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  code;
        logic [63:0] exp64;
        logic [63:0] exp48;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] dec(input logic [6:0] c, input int n);
        if (c[6] && int'(c[5:0]) < n) return 64'd1 << c[5:0];
        return 64'd0;
    endfunction

    function automatic logic [6:0] enc(input logic [63:0] w);
        for (int i = 0; i < 64; i++)
            if (w[i]) return {1'b1, 6'(i)};
        return 7'd0;
    endfunction

    task automatic compare();
        logic [63:0] h64, h48;
        h64 = (mq.size() > 0) ? dec(mq[0], 64) : 64'd0;
        h48 = (mq.size() > 0) ? dec(mq[0], 48) : 64'd0;
        chk("out_valid64", 64'(b64.out_valid), 64'(mq.size() > 0));
        chk("in_ready64",  64'(b64.in_ready),  64'(mq.size() < 2));
        chk("onehot64",    b64.onehot_out, h64);
        chk("err64",       64'(b64.err), 64'(e64));
        chk("err_count64", 64'(b64.err_count), 64'(c64));
        chk("out_valid48", 64'(b48.out_valid), 64'(mq.size() > 0));
        chk("in_ready48",  64'(b48.in_ready),  64'(mq.size() < 2));
        chk("onehot48",    64'(b48.onehot_out), h48);
        chk("err48",       64'(b48.err), 64'(e48));
        chk("err_count48", 64'(b48.err_count), 64'(c48));
    endtask

    // One clock edge: model updates from the inputs as driven, then everything is compared.
    task automatic cycle();
        bit push, pop, oor48, oor64;
        push  = vld && (mq.size() < 2);
        pop   = (mq.size() > 0) && ordy;
        oor48 = push && code[6] && (int'(code[5:0]) >= 48);
        oor64 = push && code[6] && (int'(code[5:0]) >= 64);
        @(posedge clk);
        #1;
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back(code);
        if (eclr) begin
            e48 = int'(oor48); c48 = int'(oor48);
            e64 = int'(oor64); c64 = int'(oor64);
        end else begin
            if (oor48) begin e48 = 1; c48 = (c48 < 255) ? c48 + 1 : 255; end
            if (oor64) begin e64 = 1; c64 = (c64 < 255) ? c64 + 1 : 255; end
        end
        compare();
    endtask

    // Asynchronous reset asserted between edges, checked before any edge occurs.
    task automatic mid_reset();
        vld = 1'b0;
        eclr = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid64", 64'(b64.out_valid), 64'd0);
        chk("rst_in_ready64",  64'(b64.in_ready),  64'd1);
        chk("rst_onehot64",    b64.onehot_out, 64'd0);
        chk("rst_out_valid48", 64'(b48.out_valid), 64'd0);
        chk("rst_err48",       64'(b48.err), 64'd0);
        chk("rst_err_count48", 64'(b48.err_count), 64'd0);
        mq.delete();
        e48 = 0; c48 = 0; e64 = 0; c64 = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        compare();
    endtask

    initial begin
        vec_t tbl[7];
        logic [63:0] rt[$];
        int sent;

        tbl[0] = '{7'h45, 64'h20, 64'h20};                               // {1,5}
        tbl[1] = '{7'h11, 64'h0, 64'h0};                                 // {0,17} noop
        tbl[2] = '{7'h40, 64'h1, 64'h1};                                 // {1,0}
        tbl[3] = '{7'h6F, 64'h0000_8000_0000_0000, 64'h0000_8000_0000_0000}; // {1,47}
        tbl[4] = '{7'h70, 64'h0001_0000_0000_0000, 64'h0};               // {1,48}
        tbl[5] = '{7'h7F, 64'h8000_0000_0000_0000, 64'h0};               // {1,63}
        tbl[6] = '{7'h00, 64'h0, 64'h0};                                 // {0,0}

        #1 rst = 1'b1;
        #1;
        chk("reset_in_ready",  64'(b64.in_ready), 64'd1);
        chk("reset_out_valid", 64'(b64.out_valid), 64'd0);
        chk("reset_onehot",    b64.onehot_out, 64'd0);
        chk("reset_err_count", 64'(b48.err_count), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        compare();

        // Single words, one-cycle valid, consumer always ready.
        ordy = 1'b1;
        for (int i = 0; i < 7; i++) begin
            code = tbl[i].code;
            vld  = 1'b1;
            cycle();
            vld = 1'b0;
            chk("tbl_valid", 64'(b64.out_valid), 64'd1);
            chk("tbl_word64", b64.onehot_out, tbl[i].exp64);
            chk("tbl_word48", 64'(b48.onehot_out), tbl[i].exp48);
            cycle();
            chk("tbl_drained", 64'(b64.out_valid), 64'd0);
        end
        chk("noop_no_err64", 64'(b64.err), 64'd0);

        // Backpressure: third code held upstream until a slot opens.
        ordy = 1'b0;
        vld  = 1'b1;
        code = 7'h43; cycle();
        code = 7'h47; cycle();
        chk("bp_full_ready", 64'(b64.in_ready), 64'd0);
        code = 7'h49; cycle();
        chk("bp_hold_ready", 64'(b64.in_ready), 64'd0);
        chk("bp_head0", b64.onehot_out, 64'h8);
        ordy = 1'b1;
        cycle();
        chk("bp_head1", b64.onehot_out, 64'h80);
        chk("bp_ready_back", 64'(b64.in_ready), 64'd1);
        cycle();
        vld = 1'b0;
        chk("bp_head2", b64.onehot_out, 64'h200);
        cycle();
        chk("bp_empty", 64'(b64.out_valid), 64'd0);

        // Saturating out-of-range count on the N=48 instance.
        code = 7'h72;
        vld  = 1'b1;
        for (int i = 0; i < 300; i++) begin
            cycle();
            chk("oor_word48", 64'(b48.onehot_out), 64'd0);
        end
        vld = 1'b0;
        cycle();
        chk("oor_err48", 64'(b48.err), 64'd1);
        chk("oor_sat48", 64'(b48.err_count), 64'd255);
        eclr = 1'b1;
        cycle();
        eclr = 1'b0;
        chk("clr_err48", 64'(b48.err), 64'd0);
        chk("clr_count48", 64'(b48.err_count), 64'd0);
        eclr = 1'b1;
        vld  = 1'b1;
        cycle();
        eclr = 1'b0;
        vld  = 1'b0;
        chk("clr_push_err48", 64'(b48.err), 64'd1);
        chk("clr_push_count48", 64'(b48.err_count), 64'd1);
        cycle();

        // Reset with the buffer full; nothing stale may surface afterwards.
        ordy = 1'b0;
        vld  = 1'b1;
        code = 7'h4A; cycle();
        code = 7'h4B; cycle();
        chk("pre_rst_full", 64'(b64.in_ready), 64'd0);
        mid_reset();
        ordy = 1'b1;
        cycle();
        chk("post_rst_no_stale", 64'(b64.out_valid), 64'd0);

        // Round trip of all 64 one-hot words through the encoder, random consumer stalls.
        sent = 0;
        for (int cyc = 0; cyc < 3000 && (sent < 64 || rt.size() > 0); cyc++) begin
            logic [63:0] w;
            w    = 64'd1 << sent;
            vld  = (sent < 64);
            code = (sent < 64) ? enc(w) : 7'd0;
            ordy = 1'($urandom_range(0, 1));
            if (b64.out_valid && ordy) begin
                if (rt.size() == 0) chk("rt_unexpected", b64.onehot_out, 64'd0);
                else chk("rt_word", b64.onehot_out, rt.pop_front());
            end
            if (vld && mq.size() < 2) begin
                rt.push_back(w);
                sent++;
            end
            cycle();
        end
        vld = 1'b0;
        chk("rt_done", 64'(sent == 64 && rt.size() == 0), 64'd1);
        chk("rt_err64", 64'(b64.err), 64'd0);

        // Random traffic including occasional clears and one asynchronous reset.
        for (int i = 0; i < 600; i++) begin
            vld  = 1'($urandom_range(0, 1));
            code = 7'($urandom);
            ordy = ($urandom_range(0, 3) != 0);
            eclr = ($urandom_range(0, 15) == 0);
            if (i == 300) mid_reset();
            else cycle();
        end
        vld  = 1'b0;
        eclr = 1'b0;
        ordy = 1'b1;
        cycle();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bin2onehot_stream.md
BIN2ONEHOT_STREAM -- requirements
Module: bin2onehot_stream

Interface
REQ-001 Parameter N, default 64: width of the one-hot output word; legal range 2..256, not required to be a power of two.
REQ-002 Parameter K, default $clog2(N): derived localparam, not overridable; width of the binary index.
REQ-003 Parameter DEPTH, fixed at 2: number of entries in the internal buffer.
REQ-004 wb_clk_i  input  1  sole clock; all state updates on rising edge.
REQ-005 wb_rst_i  input  1  reset, asynchronous assert, active-high.
REQ-006 in_code  input  K+1  encoded word: bit K = code-valid flag, bits K-1:0 = index.
REQ-007 in_valid  input  1  upstream offers in_code this cycle.
REQ-008 in_ready  output  1  block accepts in_code this cycle.
REQ-009 onehot_out  output  N  decoded word at buffer head.
REQ-010 out_valid  output  1  onehot_out holds a valid word.
REQ-011 out_ready  input  1  downstream consumes the head word this cycle.
REQ-012 err_clr  input  1  synchronous clear of the error status.
REQ-013 err  output  1  sticky flag: an out-of-range index was accepted.
REQ-014 err_count  output  8  saturating count of accepted out-of-range codes.

Function
REQ-015 Push occurs on an edge where in_valid=1 and in_ready=1; pop occurs on an edge where out_valid=1 and out_ready=1.
REQ-016 Buffer state machine: EMPTY (0 entries), ONE (1 entry), FULL (2 entries); push-only advances one state, pop-only retreats one state, push+pop holds state.
REQ-017 in_ready is 1 in EMPTY and ONE and 0 in FULL; it is registered-state-derived only, with no combinational path from out_ready.
REQ-018 out_valid is 1 in ONE and FULL and 0 in EMPTY; there is no combinational path from in_valid.
REQ-019 Latency: a word pushed at edge t into EMPTY is presented with out_valid=1 in the cycle after edge t; sustained throughput is one word per cycle while out_ready=1.
REQ-020 The buffer preserves FIFO order; the head word is stable while out_valid=1 and out_ready=0.
REQ-021 Decode rule: code-valid=0 gives onehot_out all zeros; code-valid=1 with index<N gives onehot_out with only bit[index]=1; code-valid=1 with index>=N gives all zeros.
REQ-022 onehot_out is all zeros whenever out_valid=0.
REQ-023 Zero-word and out-of-range codes are queued and popped like any other word; none are dropped.
REQ-024 An out-of-range code (code-valid=1, index>=N) detected at push sets err=1 and increments err_count; err_count saturates at 255.
REQ-025 err_clr=1 clears err and err_count at that edge; if an out-of-range push occurs on the same edge, the result is err=1 and err_count=1.
REQ-026 In FULL with pop and in_valid=1, no push occurs on that edge; in_ready rises in the following cycle.
REQ-027 Round trip: for every code with exactly one bit set, out_valid=1, feeding the encoder output format into this block returns the original one-hot word.

Reset
REQ-028 On wb_rst_i=1, immediately and without a clock edge: state=EMPTY, in_ready=1, out_valid=0, onehot_out=0, err=0, err_count=0; buffer contents are don't-care.
REQ-029 Reset asserted mid-transfer discards all buffered words; the first cycle after deassertion behaves as EMPTY.
REQ-030 Reset deassertion is synchronous to wb_clk_i at the integration level; no push or pop occurs on the deassertion edge.

Verification
REQ-031 Single word: in_code={1,6'd5}, one-cycle in_valid, out_ready=1 -> next cycle out_valid=1 and onehot_out=64'h20; following cycle out_valid=0.
REQ-032 Backpressure: out_ready=0, push codes 3, 7, 9 on consecutive cycles -> in_ready=0 after the second push; code 9 is held upstream; releasing out_ready yields 0x8, then 0x80, then 0x200, in that order.
REQ-033 Noop code: in_code={0,6'd17} -> out_valid=1 with onehot_out=0; err stays 0.
REQ-034 Out-of-range, N=48: push index 50 three hundred times -> onehot_out=0 each time, err=1, err_count=255; then err_clr=1 -> err=0, err_count=0.
REQ-035 Reset mid-stream: FULL buffer, assert wb_rst_i between edges -> out_valid=0 and in_ready=1 with no clock edge; after release, no stale word appears.
REQ-036 Exhaustive round trip: all 64 one-hot inputs through the encoder then this block, random out_ready -> every output equals its input, order kept, err=0.
